// File: rtl/crc32_ctrl_pkg.sv
// Shared types and constants for the CRC-32 arbitrated frame controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, CRC polynomial and defaults, result length width,
// and a bit-reverse helper used to build the LSB-first polynomial constant.
package crc32_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] CRC_POLY         = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT_DEFAULT = 32'hFFFFFFFF;
  localparam logic [31:0] XOR_OUT_DEFAULT  = 32'hFFFFFFFF;
  localparam int          LEN_W            = 16;

  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Data enters LSB first, so the shift register runs right-shifting and
  // needs the polynomial in reflected bit order.
  localparam logic [31:0] CRC_POLY_REFL = bit_reverse32(CRC_POLY);

endpackage

// File: rtl/crc32_core.sv
// Combinational 32-bit-per-cycle CRC-32 update (poly 0x04C11DB7, data bit 0 first).
// Latency: 0 cycles, pure combinational.
// Backpressure: none; evaluated every cycle, caller decides when to register.
//
// Ports: crc  - current CRC register value
//        data - 32-bit input word, bit 0 is the first bit shifted in
//        next - CRC register value after absorbing all 32 data bits
module crc32_core
  import crc32_ctrl_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [31:0] data,
  output logic [31:0] next
);

  logic [31:0] c;

  // Unrolled bit-serial LFSR; synthesis flattens this into an XOR network.
  always_comb begin
    c = crc;
    for (int i = 0; i < 32; i++) begin
      if (c[0] ^ data[i]) begin
        c = {1'b0, c[31:1]} ^ CRC_POLY_REFL;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
  end

  assign next = c;

endmodule

// File: rtl/crc32_arb_ctrl.sv
// Round-robin arbiter feeding whole frames from NUM_REQ requesters into one CRC-32 engine.
// Latency: one word per clock while granted; result registered 1 cycle after the last word.
// Backpressure: s_ready one-hot to the granted requester only; result held until m_ready.
//
// Ports: clk/rst_n            - clock, async active-low reset
//        s_valid/s_data/s_last - per-requester word streams, s_ready per-requester accept
//        m_valid/m_ready       - result handshake; m_crc/m_id/m_len result fields
//        flush                 - synchronous abort of the current frame or pending result
//        busy                  - high whenever not IDLE
module crc32_arb_ctrl
  import crc32_ctrl_pkg::*;
#(
  parameter int          NUM_REQ  = 2,
  parameter logic [31:0] CRC_INIT = CRC_INIT_DEFAULT,
  parameter logic [31:0] XOR_OUT  = XOR_OUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     s_valid,
  input  logic [32*NUM_REQ-1:0]  s_data,
  input  logic [NUM_REQ-1:0]     s_last,
  output logic [NUM_REQ-1:0]     s_ready,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [31:0]            m_crc,
  output logic [2:0]             m_id,
  output logic [LEN_W-1:0]       m_len,
  input  logic                   flush,
  output logic                   busy
);

  state_t           state_q, state_d;
  logic [2:0]       grant_q, last_grant_q, gnt_idx;
  logic             gnt_found;
  logic [7:0]       valid_pad;
  logic [3:0]       cand;
  logic [31:0]      crc_q, crc_nxt, word_sel;
  logic [LEN_W-1:0] len_q, len_inc;
  logic             accept, accept_last;

  // Round-robin search starting one past the last grant, wrapping at NUM_REQ.
  always_comb begin
    valid_pad              = '0;
    valid_pad[NUM_REQ-1:0] = s_valid;
    gnt_idx                = last_grant_q;
    gnt_found              = 1'b0;
    cand                   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_q} + 4'(k);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      if (!gnt_found && valid_pad[cand[2:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[2:0];
      end
    end
  end

  // s_ready is one-hot (or zero), so an OR-mux selects the granted word.
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s_ready[i]) begin
        word_sel = word_sel | s_data[32*i +: 32];
      end
    end
  end

  assign accept      = |(s_valid & s_ready);
  assign accept_last = |(s_valid & s_ready & s_last);
  assign len_inc     = (&len_q) ? len_q : len_q + 1'b1;

  crc32_core u_core (
    .crc  (crc_q),
    .data (word_sel),
    .next (crc_nxt)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (gnt_found) state_d = RUN;
      RUN: begin
        if (flush)            state_d = IDLE;
        else if (accept_last) state_d = DONE;
      end
      DONE: if (flush || (m_valid && m_ready)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Flush masks s_ready so a same-cycle word is never taken.
  always_comb begin
    s_ready = '0;
    busy    = (state_q != IDLE);
    if (state_q == RUN && !flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        s_ready[i] = (grant_q == 3'(i));
      end
    end
  end

  // Datapath: grant bookkeeping, CRC/length accumulation, result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= '0;
      last_grant_q <= 3'(NUM_REQ - 1);
      crc_q        <= CRC_INIT;
      len_q        <= '0;
      m_valid      <= 1'b0;
      m_crc        <= '0;
      m_id         <= '0;
      m_len        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_found) begin
            grant_q      <= gnt_idx;
            last_grant_q <= gnt_idx;
            crc_q        <= CRC_INIT;
            len_q        <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            crc_q <= crc_nxt;
            len_q <= len_inc;
            if (accept_last) begin
              m_crc   <= crc_nxt ^ XOR_OUT;
              m_len   <= len_inc;
              m_id    <= grant_q;
              m_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (flush || m_ready) begin
            m_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_arb_ctrl.sv
// Directed self-checking bench for crc32_arb_ctrl (NUM_REQ=2).
// Latency: checks result exactly 1 cycle after last accept.
// Backpressure: exercises m_ready stall, flush and mid-frame reset.
module tb_crc32_arb_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  s_valid;
  logic [63:0] s_data;
  logic [1:0]  s_last;
  logic [1:0]  s_ready;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_crc;
  logic [2:0]  m_id;
  logic [15:0] m_len;
  logic        flush;
  logic        busy;

  int tests = 0;
  int fails = 0;

  int          sent  [2];
  int          len_r [2];
  logic [31:0] wbase [2];
  logic [31:0] wstep [2];
  logic [31:0] mcrc  [2];
  logic [31:0] order;
  int          acc_cyc [8];
  int          nacc;
  int          rdy_bad;
  logic [31:0] exp_crc, exp_len, exp_id;
  logic        mv_seen;

  crc32_arb_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_crc   (m_crc),
    .m_id    (m_id),
    .m_len   (m_len),
    .flush   (flush),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: byte-at-a-time reflected CRC-32 (Ethernet), word bytes little-endian.
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] x;
    x = c;
    for (int b = 0; b < 4; b++) begin
      x = x ^ {24'h0, w[8*b +: 8]};
      for (int j = 0; j < 8; j++) begin
        x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
      end
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives frames of n0/n1 words on requesters 0/1 until all words are taken
  // and the last result has been checked. Called and returns at posedge+1.
  task automatic run(input int n0, input int n1, input logic mr, input int bound);
    int   cyc;
    logic pend;
    logic [31:0] w;
    len_r[0] = n0; len_r[1] = n1;
    sent[0]  = 0;  sent[1]  = 0;
    order = '0; nacc = 0; rdy_bad = 0; pend = 1'b0; cyc = 0;
    m_ready = mr;
    while (((sent[0] < len_r[0]) || (sent[1] < len_r[1]) || pend) && (cyc < bound)) begin
      if (pend) begin
        chk("result_latency_valid", 32'(m_valid), 32'd1);
        chk("result_crc", m_crc, exp_crc);
        chk("result_len", 32'(m_len), exp_len);
        chk("result_id", 32'(m_id), exp_id);
        pend = 1'b0;
      end
      for (int r = 0; r < 2; r++) begin
        if (sent[r] < len_r[r]) begin
          s_valid[r]         = 1'b1;
          s_data[32*r +: 32] = wbase[r] ^ (32'(sent[r]) * wstep[r]);
          s_last[r]          = (sent[r] == len_r[r] - 1);
        end else begin
          s_valid[r] = 1'b0;
          s_last[r]  = 1'b0;
        end
      end
      #1;
      if (s_ready == 2'b11) rdy_bad++;
      if (m_valid && (s_ready != 2'b00)) rdy_bad++;
      for (int r = 0; r < 2; r++) begin
        if (s_valid[r] && s_ready[r]) begin
          w = s_data[32*r +: 32];
          if (sent[r] == 0) mcrc[r] = 32'hFFFFFFFF;
          mcrc[r] = crc_model(mcrc[r], w);
          sent[r]++;
          order = {order[30:0], (r == 1)};
          if (nacc < 8) acc_cyc[nacc] = cyc;
          nacc++;
          if (s_last[r]) begin
            exp_crc = mcrc[r] ^ 32'hFFFFFFFF;
            exp_len = (sent[r] > 65535) ? 32'h0000FFFF : 32'(sent[r]);
            exp_id  = 32'(r);
            pend    = 1'b1;
          end
        end
      end
      step();
      cyc++;
    end
    chk("run_within_budget", 32'(cyc < bound), 32'd1);
    chk("ready_onehot_and_zero_in_done", 32'(rdy_bad), 32'd0);
    s_valid = 2'b00;
    s_last  = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b1; flush = 1'b0;
    wbase[0] = 32'hA0000000; wstep[0] = 32'h00000011;
    wbase[1] = 32'h0B000000; wstep[1] = 32'h00000101;
    #2;
    chk("reset_s_ready", 32'(s_ready), 32'd0);
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_m_crc", m_crc, 32'd0);
    chk("reset_m_id", 32'(m_id), 32'd0);
    chk("reset_m_len", 32'(m_len), 32'd0);
    #10 rst_n = 1'b1;
    step();

    // Contention from reset: 0 then 1, contiguous words, one IDLE bubble.
    for (int rnd = 0; rnd < 3; rnd++) begin
      run(3, 3, 1'b1, 60);
      chk("contend_order_0_then_1", order & 32'h3F, 32'h07);
      chk("contend_word_count", 32'(nacc), 32'd6);
      chk("contend_back_to_back", 32'(acc_cyc[2] - acc_cyc[0]), 32'd2);
      chk("contend_one_bubble", 32'(acc_cyc[3] - acc_cyc[2]), 32'd3);
    end

    // After a solo frame on 0, contention must favour 1.
    run(2, 0, 1'b1, 20);
    run(3, 3, 1'b1, 60);
    chk("rr_rotate_1_then_0", order & 32'h3F, 32'h38);

    // Two-word frame 00000000, 12345678 on requester 0.
    wbase[0] = 32'h00000000; wstep[0] = 32'h12345678;
    run(2, 0, 1'b1, 20);
    chk("two_word_len", 32'(m_len), 32'd2);

    // Single zero word: known CRC-32 of four zero bytes.
    wbase[0] = 32'h00000000; wstep[0] = 32'h00000000;
    run(1, 0, 1'b1, 20);
    chk("one_word_zero_crc", m_crc, 32'h2144DF1C);
    chk("one_word_len", 32'(m_len), 32'd1);

    // Backpressure on requester 1's result while both requesters wait.
    wbase[1] = 32'h5A5A0000; wstep[1] = 32'h00010203;
    run(0, 2, 1'b0, 20);
    for (int i = 0; i < 5; i++) begin
      s_valid = 2'b11; s_data = 64'hCAFEF00D_DEADBEEF; s_last = 2'b00;
      #1;
      chk("stall_m_valid", 32'(m_valid), 32'd1);
      chk("stall_m_crc", m_crc, exp_crc);
      chk("stall_m_len_id", {13'h0, m_id, m_len}, {13'h0, exp_id[2:0], exp_len[15:0]});
      chk("stall_s_ready", 32'(s_ready), 32'd0);
      step();
    end
    m_ready = 1'b1;
    step();
    chk("stall_taken_on_ready", 32'(m_valid), 32'd0);
    s_valid = 2'b00;

    // Flush while a result is pending discards it.
    wbase[0] = 32'h11111111; wstep[0] = 32'h00000003;
    run(1, 0, 1'b0, 20);
    flush = 1'b1;
    step();
    flush = 1'b0; m_ready = 1'b1;
    chk("flush_done_m_valid", 32'(m_valid), 32'd0);
    chk("flush_done_busy", 32'(busy), 32'd0);

    // Flush alongside the 2nd word of a 4-word frame.
    s_valid = 2'b01; s_data = 64'h0; s_data[31:0] = 32'h01020304; s_last = 2'b00;
    step();
    #1;
    chk("flush_pre_ready", 32'(s_ready), 32'd1);
    step();
    s_data[31:0] = 32'h05060708; flush = 1'b1;
    #1;
    chk("flush_word_not_ready", 32'(s_ready), 32'd0);
    step();
    flush = 1'b0; s_valid = 2'b00;
    chk("flush_run_busy", 32'(busy), 32'd0);
    mv_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid) mv_seen = 1'b1;
      step();
    end
    chk("flush_no_result", 32'(mv_seen), 32'd0);
    wbase[0] = 32'h01020304; wstep[0] = 32'h04040404;
    run(3, 0, 1'b1, 30);

    // Reset after 2 words of requester 0's frame.
    s_valid = 2'b01; s_data[31:0] = 32'h77777777; s_last = 2'b00;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_s_ready", 32'(s_ready), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_m_valid", 32'(m_valid), 32'd0);
    s_valid = 2'b00;
    step(); step();
    #2 rst_n = 1'b1;
    step();
    chk("rst_release_no_result", 32'(m_valid), 32'd0);
    wbase[0] = 32'hA0000000; wstep[0] = 32'h00000011;
    run(3, 3, 1'b1, 60);
    chk("rst_release_order_0_first", order & 32'h3F, 32'h07);

    // 70000-word frame: length saturates, CRC keeps accumulating.
    wbase[0] = 32'hDEADBEEF; wstep[0] = 32'h9E3779B9;
    run(70000, 0, 1'b1, 70100);
    chk("sat_len", 32'(m_len), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crc32_arb_ctrl.md
CRC32_ARB_CTRL -- requirements
Module: crc32_arb_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2; the number of frame requesters, legal range 2..8.
REQ-002 The block SHALL have parameter CRC_INIT, default 32'hFFFFFFFF; the CRC register value loaded at the start of each frame.
REQ-003 The block SHALL have parameter XOR_OUT, default 32'hFFFFFFFF; the value XORed onto the final CRC before output.
REQ-004 The block SHALL have port clk, input, 1 bit; the single clock, with all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit; an asynchronous, active-low reset.
REQ-006 The block SHALL have port s_valid, input, NUM_REQ bits; per-requester word valid.
REQ-007 The block SHALL have port s_data, input, 32*NUM_REQ bits; requester i data at [32*i +: 32].
REQ-008 The block SHALL have port s_last, input, NUM_REQ bits; per-requester last word of frame.
REQ-009 The block SHALL have port s_ready, output, NUM_REQ bits; per-requester word accepted.
REQ-010 The block SHALL have port m_valid, output, 1 bit; a result is available.
REQ-011 The block SHALL have port m_ready, input, 1 bit; the consumer takes the result.
REQ-012 The block SHALL have port m_crc, output, 32 bits; the final CRC of the frame, XOR_OUT applied.
REQ-013 The block SHALL have port m_id, output, 3 bits; the index of the requester that owned the frame.
REQ-014 The block SHALL have port m_len, output, 16 bits; the frame length in words, saturating at 16'hFFFF.
REQ-015 The block SHALL have port flush, input, 1 bit; a synchronous abort of the current frame.
REQ-016 The block SHALL have port busy, output, 1 bit; high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 In IDLE, when any s_valid bit is set, the block SHALL grant the first requester with valid set, searching round-robin from (last_grant+1) mod NUM_REQ.
- On grant it SHALL load crc_q with CRC_INIT, clear len_q, and go to RUN.
- s_ready SHALL be all-zero in IDLE.
REQ-019 After reset, last_grant SHALL equal NUM_REQ-1, so requester 0 has first priority.
REQ-020 In RUN, s_ready SHALL be one-hot at the granted index and zero elsewhere.
- A word is accepted when s_valid[g] and s_ready[g] are both high.
- On each accept: crc_q <= crc_next(crc_q, word) and len_q <= sat(len_q+1).
REQ-021 crc_next SHALL be the 32-bit-per-cycle parallel update for polynomial 0x04C11DB7, with data bit 0 treated as the least-significant input.
REQ-022 Throughput SHALL be one word per clock while the granted requester holds valid high; other requesters SHALL be stalled until the frame ends.
REQ-023 On acceptance of a word with s_last[g]=1, the block SHALL:
- register m_crc = crc_next ^ XOR_OUT, m_len = sat(len_q+1) and m_id = g;
- set m_valid;
- go to DONE;
- deassert s_ready in the following cycle.
REQ-024 The result SHALL appear on m_valid exactly 1 cycle after the last word is accepted.
REQ-025 In DONE, m_crc, m_len and m_id SHALL hold stable while m_valid=1 and m_ready=0.
- On m_valid and m_ready both high, the block SHALL clear m_valid and go to IDLE.
- This gives one bubble cycle before the next grant.
REQ-026 A frame of one word (s_last on its first word) SHALL be legal and give m_len=1.
REQ-027 The m_len counter SHALL saturate at 16'hFFFF; it SHALL NOT wrap, and CRC accumulation SHALL continue.
REQ-028 flush=1 in RUN SHALL take priority over a same-cycle accept.
- The word is not accepted: s_ready is forced to 0 that cycle.
- The block goes to IDLE, and no result is produced.
REQ-029 flush=1 in DONE SHALL clear m_valid and go to IDLE, discarding the result.
REQ-030 flush=1 in IDLE SHALL have no effect.
REQ-031 Requester valid bits SHALL be ignored while that requester is not granted.
REQ-032 last_grant SHALL update only on grant.

Reset
REQ-033 On rst_n low, the block SHALL asynchronously set:
- state=IDLE;
- s_ready=0, m_valid=0, busy=0;
- m_crc=0, m_id=0, m_len=0;
- crc_q=CRC_INIT, len_q=0, last_grant=NUM_REQ-1.
REQ-034 Reset asserted mid-frame or in DONE SHALL discard the frame and its pending result with no output.
REQ-035 Deassertion of reset SHALL be synchronised externally; the block SHALL require no cycles after reset before it can grant.

Structure
REQ-036 The shared package crc32_ctrl_pkg SHALL hold:
- the state enum type (IDLE, RUN, DONE);
- CRC_POLY = 32'h04C11DB7;
- the default CRC_INIT and XOR_OUT values;
- the m_len width constant (16).
REQ-037 The block SHALL instantiate one combinational sub-module, crc32_core (inputs crc[31:0] and data[31:0], output next[31:0]); the arbiter and FSM SHALL stay in crc32_arb_ctrl.

Verification
REQ-038 Single frame: requester 0 sends 32'h00000000 and 32'h12345678 (last); m_ready=1.
- Required: m_valid is asserted 1 cycle after the last accept.
- m_crc equals the software model's CRC over the two words, with init FFFFFFFF and final XOR FFFFFFFF.
- m_len=2 and m_id=0.
REQ-039 Contention: requesters 0 and 1 both assert valid from reset, each with a 3-word frame.
- Required: frames are served in order 0 then 1, with no interleaving of words.
- One IDLE bubble separates the frames.
- Then repeat with both valid: the order is 0 then 1 again, and a third contended round starts with 0 after 1.
REQ-040 Backpressure: hold m_ready=0 for 5 cycles after m_valid rises.
- Required: m_crc, m_len and m_id stay stable.
- s_ready stays 0 for every requester.
- The result is taken on the cycle m_ready rises.
REQ-041 Flush: assert flush together with the 2nd word of a 4-word frame.
- Required: that word is not accepted (s_ready=0) and m_valid never rises.
- The next frame's CRC equals the model value starting from CRC_INIT.
REQ-042 Reset mid-frame: drive rst_n low after 2 words of a frame.
- Required: s_ready is immediately 0 and busy=0.
- No result is produced, and requester 0 is granted first after release.
REQ-043 Saturation: send a 70000-word frame.
- Required: m_len=16'hFFFF and m_crc matches the model over all 70000 words.
